// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: default sizes, arbiter state encoding, lane-index width helper.
package xbar_pkg;

  localparam int XBAR_DATA_WIDTH = 32;
  localparam int NUM_PORT        = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  function automatic int lane_id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xbar_rr_arbiter.sv
// Combinational rotating-priority encoder: first req at or above ptr, wrapping modulo N.
// XBAR_ARB_FIXED_PRIO_EN selects plain lowest-index priority and ignores ptr.
module xbar_rr_arbiter
  import xbar_pkg::*;
#(
  parameter int N    = NUM_PORT,
  parameter int ID_W = lane_id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [ID_W-1:0] idx;
`ifdef XBAR_ARB_FIXED_PRIO_EN
      idx = ID_W'(i);
`else
      // N is a power of two, so the ID_W-bit add wraps exactly modulo N.
      idx = ptr + ID_W'(i);
`endif
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/xbar_out_arbiter_8_1_seq.sv
// Crossbar output port: round-robin lane select with packet lock, 1-entry registered output (1-cycle latency, 1 beat/cycle).
// Backpressure: o_ready only to the granted lane when the output slot is free; XBAR_ARB_FIXED_PRIO_EN selects fixed priority.
module xbar_out_arbiter_8_1_seq
  import xbar_pkg::*;
#(
  parameter int DATA_WIDTH     = XBAR_DATA_WIDTH,
  parameter int NUM_INPUT_DATA = NUM_PORT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_INPUT_DATA-1:0]            i_valid,
  input  logic [NUM_INPUT_DATA*DATA_WIDTH-1:0] i_data_bus,
  input  logic [NUM_INPUT_DATA-1:0]            i_last,
  output logic [NUM_INPUT_DATA-1:0]            o_ready,
  input  logic [NUM_INPUT_DATA-1:0]            i_lane_mask,
  input  logic                                 i_en,
  output logic                                 o_valid,
  output logic [DATA_WIDTH-1:0]                o_data,
  output logic                                 o_last,
  output logic [lane_id_width(NUM_INPUT_DATA)-1:0] o_src_id,
  input  logic                                 i_ready
);

  localparam int ID_WIDTH = lane_id_width(NUM_INPUT_DATA);

  arb_state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]       ptr, ptr_nxt;
  logic [ID_WIDTH-1:0]       lock_lane, lock_nxt;
  logic [NUM_INPUT_DATA-1:0] req, rr_grant, lock_onehot, grant;
  logic [ID_WIDTH-1:0]       rr_id, win_id;
  logic                      space, accept, acc_last;
  logic [DATA_WIDTH-1:0]     acc_data;

  assign req = i_valid & i_lane_mask;

  xbar_rr_arbiter #(
    .N    (NUM_INPUT_DATA),
    .ID_W (ID_WIDTH)
  ) u_rr (
    .req      (req),
    .ptr      (ptr),
    .grant    (rr_grant),
    .grant_id (rr_id)
  );

  // A held lock keeps its grant even if the lane's mask bit drops mid-packet.
  always_comb begin
    lock_onehot            = '0;
    lock_onehot[lock_lane] = 1'b1;
  end

  assign grant    = (state == ARB_LOCK) ? lock_onehot : rr_grant;
  assign win_id   = (state == ARB_LOCK) ? lock_lane : rr_id;
  assign space    = ~o_valid | i_ready;
  assign o_ready  = (i_en && rst && space) ? grant : '0;
  assign accept   = |(i_valid & o_ready);
  assign acc_data = i_data_bus[win_id*DATA_WIDTH +: DATA_WIDTH];
  assign acc_last = i_last[win_id];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    lock_nxt  = lock_lane;
    if (accept) begin
      if (acc_last) begin
        state_nxt = ARB_IDLE;
`ifdef XBAR_ARB_FIXED_PRIO_EN
        ptr_nxt   = '0;
`else
        ptr_nxt   = win_id + ID_WIDTH'(1);
`endif
      end else begin
        state_nxt = ARB_LOCK;
        lock_nxt  = win_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      lock_lane <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      lock_lane <= lock_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      o_valid  <= 1'b0;
      o_data   <= '0;
      o_last   <= 1'b0;
      o_src_id <= '0;
    end else if (accept) begin
      o_valid  <= 1'b1;
      o_data   <= acc_data;
      o_last   <= acc_last;
      o_src_id <= win_id;
    end else if (i_ready) begin
      o_valid  <= 1'b0;
    end
  end

endmodule
